// File: rtl/decoder_scan_nx_pkg.sv
// Shared encodings and helpers for the registered one-hot decoder family.
package dec_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Widest address the helper decodes; callers cast down to their own width.
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned MAX_DW = 2**ADDR_W;

    function automatic logic [MAX_DW-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [MAX_DW-1:0] r;
        r = '0;
        r[addr] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_nx_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high, tick on the last count.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered AW-to-2**AW one-hot decoder with optional auto-scan.
// Scan mode, dwell timer and wrap flag are built only when DECODER_SCAN_EN is defined.
module decoder_scan_nx
    import dec_pkg::*;
#(
    parameter int unsigned AW    = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              dir,
    input  logic              load,
    input  logic [AW-1:0]     add,
    output logic [2**AW-1:0]  dout,
    output logic [AW-1:0]     cur_add,
    output logic              wrap
);

    localparam int unsigned DW = 2**AW;

    state_t state;

    function automatic logic [DW-1:0] dec(input logic [AW-1:0] a);
        return DW'(onehot(ADDR_W'(a)));
    endfunction

`ifdef DECODER_SCAN_EN

    logic          scan_req;
    logic          in_scan;
    logic          tmr_run;
    logic          tmr_clr;
    logic          tick;
    logic [AW-1:0] step_add;
    logic          step_wraps;

    assign scan_req = en && (mode == MODE_SCAN);
    assign in_scan  = (state == S_SCAN);
    // Timer only runs once already in scan; entry and load both restart a full dwell.
    assign tmr_run  = scan_req && in_scan;
    assign tmr_clr  = !tmr_run || load;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .run  (tmr_run),
        .tick (tick)
    );

    always_comb begin
        step_add   = (dir == DIR_DOWN) ? cur_add - AW'(1) : cur_add + AW'(1);
        step_wraps = (dir == DIR_DOWN) ? (cur_add == '0) : (cur_add == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            dout    <= '0;
            cur_add <= '0;
            wrap    <= 1'b0;
        end else if (!en) begin
            state <= S_IDLE;
            dout  <= '0;
            wrap  <= 1'b0;
        end else if (mode == MODE_DIRECT) begin
            state   <= S_DIRECT;
            cur_add <= add;
            dout    <= dec(add);
            wrap    <= 1'b0;
        end else begin
            state <= S_SCAN;
            wrap  <= 1'b0;
            if (!in_scan) begin
                dout <= dec(cur_add);
            end else if (load) begin
                cur_add <= add;
                dout    <= dec(add);
            end else if (tick) begin
                cur_add <= step_add;
                dout    <= dec(step_add);
                wrap    <= step_wraps;
            end else begin
                dout <= dec(cur_add);
            end
        end
    end

`else

    logic unused_inputs;
    assign unused_inputs = ^{mode, dir, load, state};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            dout    <= '0;
            cur_add <= '0;
            wrap    <= 1'b0;
        end else if (!en) begin
            state <= S_IDLE;
            dout  <= '0;
            wrap  <= 1'b0;
        end else begin
            state   <= S_DIRECT;
            cur_add <= add;
            dout    <= dec(add);
            wrap    <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Directed self-checking bench for decoder_scan_nx (AW=3, DWELL=2).
module tb_decoder_scan_nx;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [2:0] add;
    logic [7:0] dout;
    logic [2:0] cur_add;
    logic       wrap;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    decoder_scan_nx #(
        .AW    (3),
        .DWELL (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .dir     (dir),
        .load    (load),
        .add     (add),
        .dout    (dout),
        .cur_add (cur_add),
        .wrap    (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [2:0] c, input logic w);
        check({tag, ".dout"}, 32'(dout), 32'(d));
        check({tag, ".cur_add"}, 32'(cur_add), 32'(c));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    logic [2:0] sweep [15] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [7:0] sweep_oh [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

`ifdef DECODER_SCAN_EN
    // Expected trace for the up-scan from 6 with DWELL=2.
    logic [2:0] up_cur  [7] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
    logic [7:0] up_dout [7] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
    logic       up_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0; load = 1'b0; add = 3'd0;

        for (int i = 0; i < 2; i++) begin
            step();
            expect_out("reset", 8'h00, 3'd0, 1'b0);
        end

        rst = 1'b0; mode = 1'b0;
        for (int i = 0; i < 15; i++) begin
            add = sweep[i];
            step();
            expect_out("direct", sweep_oh[i], sweep[i], 1'b0);
        end

`ifdef DECODER_SCAN_EN
        add = 3'd6;
        step();
        check("preset6.cur_add", 32'(cur_add), 32'd6);

        mode = 1'b1; dir = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out("scan_up", up_dout[i], up_cur[i], up_wrap[i]);
        end

        dir = 1'b1;
        step();
        expect_out("down_hold", 8'h02, 3'd1, 1'b0);
        load = 1'b1; add = 3'd5;
        step();
        expect_out("load_vs_step", 8'h20, 3'd5, 1'b0);
        load = 1'b0;
        step();
        expect_out("after_load", 8'h20, 3'd5, 1'b0);
        step();
        expect_out("down_step", 8'h10, 3'd4, 1'b0);

        load = 1'b1; add = 3'd0;
        step();
        expect_out("load0", 8'h01, 3'd0, 1'b0);
        load = 1'b0;
        step();
        expect_out("hold0", 8'h01, 3'd0, 1'b0);
        step();
        expect_out("down_wrap", 8'h80, 3'd7, 1'b1);
        step();
        expect_out("post_wrap", 8'h80, 3'd7, 1'b0);

        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("off", 8'h00, 3'd7, 1'b0);
        end
        en = 1'b1;
        step();
        expect_out("resume", 8'h80, 3'd7, 1'b0);
        step();
        expect_out("resume_hold", 8'h80, 3'd7, 1'b0);
        step();
        expect_out("resume_step", 8'h40, 3'd6, 1'b0);

        en = 1'b0; load = 1'b1; add = 3'd2;
        step();
        expect_out("load_idle", 8'h00, 3'd6, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        expect_out("rst_midscan", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
`else
        mode = 1'b1; load = 1'b1; dir = 1'b1; add = 3'd3;
        step();
        expect_out("nomacro", 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("nomacro_hold", 8'h08, 3'd3, 1'b0);
        end
        add = 3'd7;
        step();
        expect_out("nomacro_add7", 8'h80, 3'd7, 1'b0);
        en = 1'b0;
        step();
        expect_out("nomacro_off", 8'h00, 3'd7, 1'b0);
        rst = 1'b1;
        step();
        expect_out("nomacro_rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
